// File: rtl/idma_aw_coupler_pkg.sv
// Shared constants and helpers for the AW coupler and its FIFO.
package idma_aw_coupler_pkg;

  localparam int unsigned DefaultAxInFlight = 8;

  function automatic bit is_pow2_min2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/idma_sync_fifo.sv
// In-order FIFO, synchronous active-high reset, no fall-through (read data is registered state).
module idma_sync_fifo
  import idma_aw_coupler_pkg::*;
#(
  parameter int unsigned Depth   = DefaultAxInFlight,
  parameter type         dtype_t = logic
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  dtype_t data_i,
  output logic   full_o,
  input  logic   pop_i,
  output dtype_t data_o,
  output logic   empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] PtrOne = 1;

  // Extra MSB on each pointer tells full from empty when the indices match.
  logic [AddrW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  dtype_t         mem_q [Depth];
  logic           push, pop;

  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
  end

`ifndef SYNTHESIS
  a_depth_legal: assert property (@(posedge clk_i) is_pow2_min2(Depth));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));
`endif

endmodule

// File: rtl/idma_aw_coupler.sv
// Holds write AWs back until the matching read burst has delivered its first R beat,
// unless the AW is flagged decoupled; strict in-order issue, one-cycle buffer latency.
module idma_aw_coupler
  import idma_aw_coupler_pkg::*;
#(
  parameter int unsigned NumAxInFlight = DefaultAxInFlight,
  parameter type         aw_chan_t     = logic
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  aw_chan_t aw_req_i,
  input  logic     aw_decouple_i,
  input  logic     aw_valid_i,
  output logic     aw_ready_o,
  input  logic     r_first_i,
  input  logic     r_decouple_i,
  output aw_chan_t aw_req_o,
  output logic     aw_valid_o,
  input  logic     aw_ready_i,
  output logic     busy_o
);

  localparam int unsigned CntW   = $clog2(NumAxInFlight + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(NumAxInFlight);
  localparam logic [CntW-1:0] CntOne = 1;

  typedef struct packed {
    aw_chan_t aw;
    logic     decouple;
  } entry_t;

  entry_t          in_entry, head;
  logic            full, empty, push, pop;
  logic            inc, coupled_pop, aw_release;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    in_entry          = '0;
    in_entry.aw       = aw_req_i;
    in_entry.decouple = aw_decouple_i;
  end

  idma_sync_fifo #(
    .Depth   (NumAxInFlight),
    .dtype_t (entry_t)
  ) i_aw_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (in_entry),
    .full_o  (full),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (empty)
  );

  assign aw_ready_o = ~full;
  assign push       = aw_valid_i & aw_ready_o;

  // A credit arriving this cycle releases the head immediately instead of a cycle later.
  assign inc         = r_first_i & ~r_decouple_i;
  assign aw_release  = head.decouple | (cnt_q != '0) | inc;
  assign aw_valid_o  = ~empty & aw_release;
  assign aw_req_o    = head.aw;
  assign pop         = aw_valid_o & aw_ready_i;
  assign coupled_pop = pop & ~head.decouple;
  assign busy_o      = ~empty | (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !coupled_pop) begin
      if (cnt_q != MaxCnt) cnt_d = cnt_q + CntOne;
    end else if (!inc && coupled_pop) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

`ifndef SYNTHESIS
  a_cnt_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(inc && !coupled_pop && (cnt_q == MaxCnt)));
  a_aw_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (aw_valid_o && !aw_ready_i) |=> (aw_valid_o && $stable(aw_req_o)));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && full));
`endif

endmodule

// File: tb/tb_idma_aw_coupler.sv
// Directed bench for idma_aw_coupler: cycle vector table plus hand sequences for stall, full and reset.
module tb_idma_aw_coupler;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
  } aw_t;

  typedef struct {
    logic        av;
    logic [31:0] addr;
    logic        dec;
    logic        rf;
    logic        rd;
    logic        ar;
    logic        vo;
    logic        ro;
    logic        bo;
    logic [31:0] eaddr;
    int          cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  aw_t  aw_req_i = '0;
  logic aw_decouple_i = 1'b0, aw_valid_i = 1'b0;
  logic r_first_i = 1'b0, r_decouple_i = 1'b0, aw_ready_i = 1'b0;
  logic aw_ready_o, aw_valid_o, busy_o;
  aw_t  aw_req_o;

  int n_cmp = 0;
  int n_fail = 0;

  idma_aw_coupler #(
    .NumAxInFlight (8),
    .aw_chan_t     (aw_t)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .aw_req_i      (aw_req_i),
    .aw_decouple_i (aw_decouple_i),
    .aw_valid_i    (aw_valid_i),
    .aw_ready_o    (aw_ready_o),
    .r_first_i     (r_first_i),
    .r_decouple_i  (r_decouple_i),
    .aw_req_o      (aw_req_o),
    .aw_valid_o    (aw_valid_o),
    .aw_ready_i    (aw_ready_i),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then wait to the falling edge for sampling.
  task automatic cyc(input logic rst, input logic av, input logic [31:0] addr, input logic dec,
                     input logic rf, input logic rd, input logic ar);
    @(posedge clk);
    #1;
    rst_i         = rst;
    aw_valid_i    = av;
    aw_req_i      = '{addr: addr, id: 4'h0};
    aw_decouple_i = dec;
    r_first_i     = rf;
    r_decouple_i  = rd;
    aw_ready_i    = ar;
    @(negedge clk);
  endtask

  task automatic idle(input logic ar);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, ar);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".valid"}, {31'b0, aw_valid_o}, 32'd0);
    check({tag, ".ready"}, {31'b0, aw_ready_o}, 32'd1);
    check({tag, ".busy"},  {31'b0, busy_o},     32'd0);
    check({tag, ".cnt"},   32'(dut.cnt_q),      32'd0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
  endtask

  function automatic vec_t mk(input logic av, input logic [31:0] addr, input logic dec,
                              input logic rf, input logic rd, input logic ar,
                              input logic vo, input logic ro, input logic bo,
                              input logic [31:0] eaddr, input int cnt);
    vec_t v;
    v.av = av; v.addr = addr; v.dec = dec; v.rf = rf; v.rd = rd; v.ar = ar;
    v.vo = vo; v.ro = ro; v.bo = bo; v.eaddr = eaddr; v.cnt = cnt;
    return v;
  endfunction

  vec_t vecs[25];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, expected below 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    //            av addr          dec rf rd ar   vo ro bo eaddr         cnt
    // decoupled stream: each AW shows up one cycle after its push
    vecs[0]  = mk(1, 32'h1000, 1, 0, 0, 1,  0, 1, 0, 32'h0,    0);
    vecs[1]  = mk(1, 32'h1010, 1, 0, 0, 1,  1, 1, 1, 32'h1000, 0);
    vecs[2]  = mk(1, 32'h1020, 1, 0, 0, 1,  1, 1, 1, 32'h1010, 0);
    vecs[3]  = mk(0, 32'h0,    0, 0, 0, 1,  1, 1, 1, 32'h1020, 0);
    vecs[4]  = mk(0, 32'h0,    0, 0, 0, 1,  0, 1, 0, 32'h0,    0);
    // credits first, then two coupled AWs released back-to-back
    vecs[5]  = mk(0, 32'h0,    0, 1, 0, 1,  0, 1, 0, 32'h0,    0);
    vecs[6]  = mk(0, 32'h0,    0, 1, 0, 1,  0, 1, 1, 32'h0,    1);
    vecs[7]  = mk(1, 32'h2000, 0, 0, 0, 1,  0, 1, 1, 32'h0,    2);
    vecs[8]  = mk(1, 32'h2010, 0, 0, 0, 1,  1, 1, 1, 32'h2000, 2);
    vecs[9]  = mk(0, 32'h0,    0, 0, 0, 1,  1, 1, 1, 32'h2010, 1);
    vecs[10] = mk(0, 32'h0,    0, 0, 0, 1,  0, 1, 0, 32'h0,    0);
    // head-of-line: coupled head blocks a younger decoupled AW
    vecs[11] = mk(1, 32'h3000, 0, 0, 0, 1,  0, 1, 0, 32'h0,    0);
    vecs[12] = mk(1, 32'h3010, 1, 0, 0, 1,  0, 1, 1, 32'h0,    0);
    vecs[13] = mk(0, 32'h0,    0, 0, 0, 1,  0, 1, 1, 32'h0,    0);
    vecs[14] = mk(0, 32'h0,    0, 0, 0, 1,  0, 1, 1, 32'h0,    0);
    vecs[15] = mk(0, 32'h0,    0, 1, 0, 1,  1, 1, 1, 32'h3000, 0);
    vecs[16] = mk(0, 32'h0,    0, 0, 0, 1,  1, 1, 1, 32'h3010, 0);
    vecs[17] = mk(0, 32'h0,    0, 0, 0, 1,  0, 1, 0, 32'h0,    0);
    // decoupled read bursts earn no credit
    vecs[18] = mk(0, 32'h0,    0, 1, 1, 1,  0, 1, 0, 32'h0,    0);
    vecs[19] = mk(0, 32'h0,    0, 0, 0, 1,  0, 1, 0, 32'h0,    0);
    // bypass-released AW not taken: credit is banked and valid holds
    vecs[20] = mk(1, 32'h4000, 0, 0, 0, 0,  0, 1, 0, 32'h0,    0);
    vecs[21] = mk(0, 32'h0,    0, 1, 0, 0,  1, 1, 1, 32'h4000, 0);
    vecs[22] = mk(0, 32'h0,    0, 0, 0, 0,  1, 1, 1, 32'h4000, 1);
    vecs[23] = mk(0, 32'h0,    0, 0, 0, 1,  1, 1, 1, 32'h4000, 1);
    vecs[24] = mk(0, 32'h0,    0, 0, 0, 1,  0, 1, 0, 32'h0,    0);

    do_reset();
    check_quiet("post_reset");

    for (int i = 0; i < 25; i++) begin
      cyc(1'b0, vecs[i].av, vecs[i].addr, vecs[i].dec, vecs[i].rf, vecs[i].rd, vecs[i].ar);
      check($sformatf("vec%0d.valid", i), {31'b0, aw_valid_o}, {31'b0, vecs[i].vo});
      check($sformatf("vec%0d.ready", i), {31'b0, aw_ready_o}, {31'b0, vecs[i].ro});
      check($sformatf("vec%0d.busy", i),  {31'b0, busy_o},     {31'b0, vecs[i].bo});
      check($sformatf("vec%0d.cnt", i),   32'(dut.cnt_q),      32'(vecs[i].cnt));
      if (vecs[i].vo)
        check($sformatf("vec%0d.addr", i), aw_req_o.addr, vecs[i].eaddr);
    end

    // Coupled stall: AW waits for its first R beat, released in the same cycle.
    do_reset();
    cyc(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      idle(1'b1);
      check($sformatf("stall%0d.valid", i), {31'b0, aw_valid_o}, 32'd0);
    end
    check("stall.busy", {31'b0, busy_o}, 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("stall.release_valid", {31'b0, aw_valid_o}, 32'd1);
    check("stall.release_addr", aw_req_o.addr, 32'h100);
    idle(1'b1);
    check_quiet("stall.after");

    // Full FIFO: eight decoupled AWs with downstream stalled.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 32'h200 + 32'(i) * 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("fill%0d.ready", i), {31'b0, aw_ready_o}, 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 32'hdead0, 1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("full%0d.ready", i), {31'b0, aw_ready_o}, 32'd0);
      check($sformatf("full%0d.valid", i), {31'b0, aw_valid_o}, 32'd1);
      check($sformatf("full%0d.addr", i),  aw_req_o.addr,       32'h200);
    end
    cyc(1'b0, 1'b1, 32'hdead0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("full.pop_ready", {31'b0, aw_ready_o}, 32'd0);
    check("full.pop_addr",  aw_req_o.addr,       32'h200);
    idle(1'b0);
    check("full.reopen_ready", {31'b0, aw_ready_o}, 32'd1);
    check("full.next_head",    aw_req_o.addr,       32'h210);
    for (int i = 1; i < 8; i++) begin
      idle(1'b1);
      check($sformatf("drain%0d.valid", i), {31'b0, aw_valid_o}, 32'd1);
      check($sformatf("drain%0d.addr", i),  aw_req_o.addr,       32'h200 + 32'(i) * 32'h10);
    end
    idle(1'b1);
    check_quiet("drain.empty");

    // Reset mid-operation: 5 coupled AWs buffered, 3 credits banked.
    do_reset();
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b1, 32'h500 + 32'(i) * 32'h10, 1'b0, (i < 3) ? 1'b1 : 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("midop.cnt",   32'(dut.cnt_q),      32'd3);
    check("midop.valid", {31'b0, aw_valid_o}, 32'd1);
    check("midop.busy",  {31'b0, busy_o},     32'd1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_quiet("midop.reset");
    cyc(1'b0, 1'b1, 32'h600, 1'b1, 1'b0, 1'b0, 1'b1);
    check("midop.push_valid", {31'b0, aw_valid_o}, 32'd0);
    idle(1'b1);
    check("midop.fresh_valid", {31'b0, aw_valid_o}, 32'd1);
    check("midop.fresh_addr",  aw_req_o.addr,       32'h600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
